game_display_timing: RTL

Raster timing generator that drives the pixel-coordinate interface consumed by the game renderer. It produces VGA sync pulses, a visible-area enable, and the game-space coordinates `sx`/`sy` with `frame_stb` and `game_pix_stb` for a GAME_W×GAME_H window. The window is centred in the visible raster and integer-upscaled by SCALE. It sits between the pixel-clock source and the renderer; the renderer's RGB output is muxed by `display_enabled` at the top level.

---
 rtl/game_display_timing_pkg.sv | 28 ++
 rtl/game_display_timing_if.sv | 30 +++
 rtl/game_display_timing_raster_axis_counter.sv | 108 ++++++++++
 rtl/game_display_timing.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/game_display_timing_pkg.sv
// Shared constants for the raster timing generator.
//   VGA_*    : 640x480@60 timing (visible, porches, sync), in clocks / lines.
//   PACMAN_* : game window size in virtual pixels.
//   width_of : counter width for a range of n values, never below 1 bit.
package game_display_timing_pkg;

  // VGA line timing, in pixel clocks
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;

  // VGA frame timing, in lines
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  // Game window, in virtual pixels
  localparam int unsigned PACMAN_GAME_W = 224;
  localparam int unsigned PACMAN_GAME_H = 288;

  // Bits needed to hold 0..n-1; degenerate ranges still get one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_display_timing_if.sv
// Pixel-coordinate bus from the timing generator to the renderer.
//   hsync/vsync     : active-low syncs
//   display_enabled : inside the visible raster
//   game_en         : inside the game window
//   sx/sy           : game column/row, 0 outside the window
//   frame_stb       : one pulse at raw (0,0)
//   game_pix_stb    : first clock of each virtual pixel in the window
interface game_display_timing_if #(
  parameter int unsigned SX_W = 8,
  parameter int unsigned SY_W = 9
);

  logic            hsync;
  logic            vsync;
  logic            display_enabled;
  logic            game_en;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic            frame_stb;
  logic            game_pix_stb;

  modport master (
    output hsync, vsync, display_enabled, game_en, sx, sy, frame_stb, game_pix_stb
  );

  modport slave (
    input hsync, vsync, display_enabled, game_en, sx, sy, frame_stb, game_pix_stb
  );

endinterface

// File: rtl/game_display_timing_raster_axis_counter.sv
// One raster axis (horizontal or vertical): position counter with wrap,
// sync-window compare, and a scaled game-window sub-counter that yields the
// game coordinate without a divider.
// Every *_c_o output describes the position the axis moves to on the next
// edge, so the parent can register all of its outputs from the same position.
//   clk, rst_n    : clock, async active-low reset
//   clr_i         : next position is 0 (restart after reset)
//   step_i        : advance one position this cycle
//   last_c_o      : current position is the last of the axis
//   zero_c_o      : next position is 0
//   sync_n_c_o    : next position is outside the sync pulse
//   vis_c_o       : next position is in the visible range
//   win_c_o       : next position is in the game window
//   sub_zero_c_o  : next position starts a virtual pixel
//   coord_c_o     : game coordinate of next position (0 outside window)
module game_display_timing_raster_axis_counter
  import game_display_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter int unsigned WIN_OFF = 208,
  parameter int unsigned WIN_LEN = 224,
  parameter int unsigned SCALE   = 1,
  parameter int unsigned COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               step_i,
  output logic               last_c_o,
  output logic               zero_c_o,
  output logic               sync_n_c_o,
  output logic               vis_c_o,
  output logic               win_c_o,
  output logic               sub_zero_c_o,
  output logic [COORD_W-1:0] coord_c_o
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam int unsigned POS_W = width_of(TOTAL);
  localparam int unsigned SUB_W = width_of(SCALE);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] VIS_END  = POS_W'(VISIBLE);
  localparam logic [POS_W-1:0] SYNC_LO  = POS_W'(VISIBLE + FRONT);
  localparam logic [POS_W-1:0] SYNC_HI  = POS_W'(VISIBLE + FRONT + SYNC);
  localparam logic [POS_W-1:0] WIN_LO   = POS_W'(WIN_OFF);
  localparam logic [POS_W-1:0] WIN_HI   = POS_W'(WIN_OFF + WIN_LEN);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  logic [POS_W-1:0]   pos_q,   pos_d;
  logic [SUB_W-1:0]   sub_q,   sub_d;
  logic [COORD_W-1:0] coord_q, coord_d;
  logic [POS_W-1:0]   pos_inc;
  logic               win_inc;

  assign last_c_o = (pos_q == POS_LAST);
  assign pos_inc  = last_c_o ? '0 : pos_q + POS_W'(1);
  assign win_inc  = (pos_inc >= WIN_LO) && (pos_inc < WIN_HI);

  // Next position, sub-phase and coordinate; the coordinate steps each time
  // the sub-phase wraps, which replaces (pos - WIN_OFF) / SCALE.
  always_comb begin
    pos_d   = pos_q;
    sub_d   = sub_q;
    coord_d = coord_q;
    if (clr_i) begin
      pos_d   = '0;
      sub_d   = '0;
      coord_d = '0;
    end else if (step_i) begin
      pos_d = pos_inc;
      if (!win_inc || (pos_inc == WIN_LO)) begin
        sub_d   = '0;
        coord_d = '0;
      end else if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        coord_d = coord_q + COORD_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // Axis state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      sub_q   <= '0;
      coord_q <= '0;
    end else begin
      pos_q   <= pos_d;
      sub_q   <= sub_d;
      coord_q <= coord_d;
    end
  end

  // Decodes of the next position for the parent's output registers
  assign zero_c_o     = (pos_d == '0);
  assign sync_n_c_o   = !((pos_d >= SYNC_LO) && (pos_d < SYNC_HI));
  assign vis_c_o      = (pos_d < VIS_END);
  assign win_c_o      = (pos_d >= WIN_LO) && (pos_d < WIN_HI);
  assign sub_zero_c_o = (sub_d == '0);
  assign coord_c_o    = coord_d;

endmodule

// File: rtl/game_display_timing.sv
// Raster timing generator: VGA syncs, visible enable, and a centred,
// integer-upscaled game window with game-space coordinates and strobes.
// All outputs are registered from one raw position (h,v), so renderer RGB
// derived combinationally from sx/sy stays aligned with the syncs.
//   vga_pix_clk : pixel clock
//   rst_n       : async active-low reset; restart is always at (0,0)
//   raster_o    : pixel-coordinate bus (master side)
module game_display_timing
  import game_display_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned GAME_W    = PACMAN_GAME_W,
  parameter int unsigned GAME_H    = PACMAN_GAME_H,
  parameter int unsigned SCALE     = 1
) (
  input  logic                   vga_pix_clk,
  input  logic                   rst_n,
  game_display_timing_if.master  raster_o
);

  localparam int unsigned SX_W  = width_of(GAME_W);
  localparam int unsigned SY_W  = width_of(GAME_H);
  localparam int unsigned H_WIN = GAME_W * SCALE;
  localparam int unsigned V_WIN = GAME_H * SCALE;
  // Guarded so an illegal size reports the error below instead of wrapping
  localparam int unsigned H_OFF = (H_WIN <= H_VISIBLE) ? (H_VISIBLE - H_WIN) / 2 : 0;
  localparam int unsigned V_OFF = (V_WIN <= V_VISIBLE) ? (V_VISIBLE - V_WIN) / 2 : 0;

  if ((SCALE < 1) || (H_WIN > H_VISIBLE) || (V_WIN > V_VISIBLE)) begin : g_param_check
    $error("game_display_timing: scaled game window does not fit the visible raster");
  end

  logic            run_q;
  logic            hsync_q,  hsync_d;
  logic            vsync_q,  vsync_d;
  logic            de_q,     de_d;
  logic            game_en_q, game_en_d;
  logic [SX_W-1:0] sx_q,     sx_d;
  logic [SY_W-1:0] sy_q,     sy_d;
  logic            frame_stb_q, frame_stb_d;
  logic            pix_stb_q,   pix_stb_d;

  logic            h_last_c, h_zero_c, h_sync_n_c, h_vis_c, h_win_c, h_sub_zero_c;
  logic            v_last_c, v_zero_c, v_sync_n_c, v_vis_c, v_win_c, v_sub_zero_c;
  logic [SX_W-1:0] h_coord_c;
  logic [SY_W-1:0] v_coord_c;
  logic            unused_v_decodes;

  // Horizontal axis steps every clock once running
  game_display_timing_raster_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .WIN_OFF (H_OFF),
    .WIN_LEN (H_WIN),
    .SCALE   (SCALE),
    .COORD_W (SX_W)
  ) u_h_axis (
    .clk          (vga_pix_clk),
    .rst_n        (rst_n),
    .clr_i        (!run_q),
    .step_i       (run_q),
    .last_c_o     (h_last_c),
    .zero_c_o     (h_zero_c),
    .sync_n_c_o   (h_sync_n_c),
    .vis_c_o      (h_vis_c),
    .win_c_o      (h_win_c),
    .sub_zero_c_o (h_sub_zero_c),
    .coord_c_o    (h_coord_c)
  );

  // Vertical axis steps when the line wraps
  game_display_timing_raster_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .WIN_OFF (V_OFF),
    .WIN_LEN (V_WIN),
    .SCALE   (SCALE),
    .COORD_W (SY_W)
  ) u_v_axis (
    .clk          (vga_pix_clk),
    .rst_n        (rst_n),
    .clr_i        (!run_q),
    .step_i       (run_q && h_last_c),
    .last_c_o     (v_last_c),
    .zero_c_o     (v_zero_c),
    .sync_n_c_o   (v_sync_n_c),
    .vis_c_o      (v_vis_c),
    .win_c_o      (v_win_c),
    .sub_zero_c_o (v_sub_zero_c),
    .coord_c_o    (v_coord_c)
  );

  // Frame wrap and row sub-phase are implied by the other decodes
  assign unused_v_decodes = &{1'b0, v_last_c, v_sub_zero_c};

  // Output decode for the position both axes move to on this edge
  always_comb begin
    hsync_d     = h_sync_n_c;
    vsync_d     = v_sync_n_c;
    de_d        = h_vis_c && v_vis_c;
    game_en_d   = h_win_c && v_win_c;
    sx_d        = '0;
    sy_d        = '0;
    frame_stb_d = h_zero_c && v_zero_c;
    pix_stb_d   = game_en_d && h_sub_zero_c;
    if (game_en_d) begin
      sx_d = h_coord_c;
      sy_d = v_coord_c;
    end
  end

  // Output registers; run_q makes the first edge after reset present (0,0)
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      game_en_q   <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      frame_stb_q <= 1'b0;
      pix_stb_q   <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      game_en_q   <= game_en_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      frame_stb_q <= frame_stb_d;
      pix_stb_q   <= pix_stb_d;
    end
  end

  assign raster_o.hsync           = hsync_q;
  assign raster_o.vsync           = vsync_q;
  assign raster_o.display_enabled = de_q;
  assign raster_o.game_en         = game_en_q;
  assign raster_o.sx              = sx_q;
  assign raster_o.sy              = sy_q;
  assign raster_o.frame_stb       = frame_stb_q;
  assign raster_o.game_pix_stb    = pix_stb_q;

endmodule
